// File: rtl/data_mem_pkg.sv
// Shared types and default geometry for the sweeping data memory.
// Used by data_mem_sweep, mem_clear_seq and the controller side.
package data_mem_pkg;

  typedef enum logic [1:0] {
    START    = 2'd0,
    CLEARING = 2'd1,
    IDLE     = 2'd2
  } state_t;

  localparam int DEF_W     = 8;
  localparam int DEF_A     = 8;
  localparam int DEF_DEPTH = 1 << DEF_A;

endpackage

// File: rtl/mem_clear_seq.sv
// Clear-sweep sequencer: START/CLEARING/IDLE FSM and sweep counter.
// In: clk, reset, clear_request. Out: ready, sweep_we, sweep_addr.
module mem_clear_seq
  import data_mem_pkg::*;
#(
  parameter int A              = DEF_A,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear_request,
  output logic         ready,
  output logic         sweep_we,
  output logic [A-1:0] sweep_addr
);

  state_t       state;
  state_t       state_nx;
  logic [A-1:0] count;
  logic [A-1:0] count_nx;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= START;
      count <= '0;
    end else begin
      state <= state_nx;
      count <= count_nx;
    end
  end

  // The counter wraps to 0 on the last sweep write, so
  // IDLE always holds count == 0.
  always_comb begin
    state_nx = state;
    count_nx = count;
    unique case (1'b1)
      (state == START): begin
        count_nx = '0;
        state_nx = CLEAR_ON_RESET ? CLEARING : IDLE;
      end
      (state == CLEARING): begin
        count_nx = count + 1'b1;
        if (count == '1) state_nx = IDLE;
      end
      (state == IDLE): begin
        if (clear_request) begin
          count_nx = '0;
          state_nx = CLEARING;
        end
      end
      default: begin
        count_nx = '0;
        state_nx = START;
      end
    endcase
  end

  always_comb begin
    ready      = (state == IDLE);
    sweep_we   = (state == CLEARING);
    sweep_addr = count;
  end

endmodule

// File: rtl/data_mem_sweep.sv
// Single-port data memory with registered read and hardware clear sweep.
// Ports: clk, reset, data_to_write, addr, read/write_enabled,
// clear_request -> data_out, read_valid, ready, access_error.
module data_mem_sweep
  import data_mem_pkg::*;
#(
  parameter int           W              = DEF_W,
  parameter int           A              = DEF_A,
  parameter bit           CLEAR_ON_RESET = 1'b1,
  parameter logic [W-1:0] CLEAR_VALUE    = '0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] data_to_write,
  input  logic [A-1:0] addr,
  input  logic         read_enabled,
  input  logic         write_enabled,
  input  logic         clear_request,
  output logic [W-1:0] data_out,
  output logic         read_valid,
  output logic         ready,
  output logic         access_error
);

  localparam int DEPTH = 1 << A;

  logic [W-1:0] core [DEPTH];

  logic         sweep_we;
  logic [A-1:0] sweep_addr;
  logic         mem_we;
  logic [A-1:0] mem_addr;
  logic [W-1:0] mem_wdata;
  logic         req_any;
  logic         rd_ok;

  mem_clear_seq #(
    .A              (A),
    .CLEAR_ON_RESET (CLEAR_ON_RESET)
  ) u_seq (
    .clk           (clk),
    .reset         (reset),
    .clear_request (clear_request),
    .ready         (ready),
    .sweep_we      (sweep_we),
    .sweep_addr    (sweep_addr)
  );

  // Sweep owns the write port; core stores only land when ready.
  assign mem_we    = sweep_we | (ready & write_enabled);
  assign mem_addr  = sweep_we ? sweep_addr : addr;
  assign mem_wdata = sweep_we ? CLEAR_VALUE : data_to_write;

  assign req_any = read_enabled | write_enabled | clear_request;
  assign rd_ok   = ready & read_enabled;

  always_ff @(posedge clk) begin
    if (mem_we) core[mem_addr] <= mem_wdata;
  end

  // Read samples the pre-write contents: read-first on collision.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_out     <= '0;
      read_valid   <= 1'b0;
      access_error <= 1'b0;
    end else begin
      read_valid   <= rd_ok;
      access_error <= ~ready & req_any;
      if (rd_ok) data_out <= core[addr];
    end
  end

endmodule

// File: tb/tb_data_mem_sweep.sv
// Self-checking bench for data_mem_sweep (A=4, W=8).
// Three instances: default, CLEAR_VALUE=3C, CLEAR_ON_RESET=0.
module tb_data_mem_sweep;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst [3];
  logic       rd  [3];
  logic       wr  [3];
  logic       clr [3];
  logic [3:0] ad  [3];
  logic [7:0] wd  [3];

  logic [7:0] a_dq, b_dq, c_dq;
  logic       a_rv, b_rv, c_rv;
  logic       a_rdy, b_rdy, c_rdy;
  logic       a_err, b_err, c_err;

  data_mem_sweep #(
    .W(8), .A(4), .CLEAR_ON_RESET(1'b1), .CLEAR_VALUE(8'h00)
  ) dut_a (
    .clk(clk), .reset(rst[0]), .data_to_write(wd[0]),
    .addr(ad[0]), .read_enabled(rd[0]), .write_enabled(wr[0]),
    .clear_request(clr[0]), .data_out(a_dq), .read_valid(a_rv),
    .ready(a_rdy), .access_error(a_err)
  );

  data_mem_sweep #(
    .W(8), .A(4), .CLEAR_ON_RESET(1'b1), .CLEAR_VALUE(8'h3C)
  ) dut_b (
    .clk(clk), .reset(rst[1]), .data_to_write(wd[1]),
    .addr(ad[1]), .read_enabled(rd[1]), .write_enabled(wr[1]),
    .clear_request(clr[1]), .data_out(b_dq), .read_valid(b_rv),
    .ready(b_rdy), .access_error(b_err)
  );

  data_mem_sweep #(
    .W(8), .A(4), .CLEAR_ON_RESET(1'b0), .CLEAR_VALUE(8'h00)
  ) dut_c (
    .clk(clk), .reset(rst[2]), .data_to_write(wd[2]),
    .addr(ad[2]), .read_enabled(rd[2]), .write_enabled(wr[2]),
    .clear_request(clr[2]), .data_out(c_dq), .read_valid(c_rv),
    .ready(c_rdy), .access_error(c_err)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  logic [7:0] sb [$];

  typedef struct {
    logic       r;
    logic       w;
    logic [3:0] a;
    logic [7:0] d;
    logic [7:0] e;
  } vec_t;

  vec_t tbl [$];

  function automatic vec_t mk(logic r, logic w, logic [3:0] a,
                              logic [7:0] d, logic [7:0] e);
    vec_t v;
    v.r = r; v.w = w; v.a = a; v.d = d; v.e = e;
    return v;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step(int i, logic r, logic w, logic c,
                      logic [3:0] a, logic [7:0] d);
    rd[i]  = r;
    wr[i]  = w;
    clr[i] = c;
    ad[i]  = a;
    wd[i]  = d;
    @(posedge clk);
    #1;
  endtask

  // Scoreboard for instance a: each read_valid pops one expectation.
  always @(negedge clk) begin
    if (a_rv === 1'b1) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL sb_spurious: read_valid=1 data=%0h, none expected",
                 a_dq);
      end else begin
        chk("sb_data", a_dq, sb.pop_front());
      end
    end
  end

  initial begin
    for (int i = 0; i < 3; i++) begin
      rst[i] = 1'b1; rd[i] = 1'b0; wr[i] = 1'b0;
      clr[i] = 1'b0; ad[i] = '0; wd[i] = '0;
    end
    #2;
    for (int i = 0; i < 3; i++) rst[i] = 1'b0;

    // Instance a: reset values, then START + 16-cycle sweep.
    repeat (3) @(posedge clk);
    #1;
    rd[0] = 1'b1;
    chk("rst_ready", a_rdy, 0);
    chk("rst_rv", a_rv, 0);
    chk("rst_err", a_err, 0);
    chk("rst_dq", a_dq, 0);
    rd[0] = 1'b0;
    rst[0] = 1'b1;
    for (int k = 1; k <= 17; k++) begin
      step(0, 0, 0, 0, 0, 0);
      chk($sformatf("boot_ready_%0d", k), a_rdy, (k == 17));
    end

    // Table of reads/writes including read-first collision.
    for (int k = 0; k < 16; k++)
      tbl.push_back(mk(1, 0, 4'(k), 8'h00, 8'h00));
    tbl.push_back(mk(0, 1, 4'h3, 8'hA5, 8'h00));
    tbl.push_back(mk(1, 0, 4'h3, 8'h00, 8'hA5));
    tbl.push_back(mk(0, 0, 4'h0, 8'h00, 8'h00));
    tbl.push_back(mk(1, 1, 4'h3, 8'h5A, 8'hA5));
    tbl.push_back(mk(1, 0, 4'h3, 8'h00, 8'h5A));
    tbl.push_back(mk(0, 0, 4'h0, 8'h00, 8'h00));
    foreach (tbl[k]) begin
      if (tbl[k].r) sb.push_back(tbl[k].e);
      step(0, tbl[k].r, tbl[k].w, 0, tbl[k].a, tbl[k].d);
      chk($sformatf("tbl_rv_%0d", k), a_rv, tbl[k].r);
      chk($sformatf("tbl_err_%0d", k), a_err, 0);
      chk($sformatf("tbl_ready_%0d", k), a_rdy, 1);
    end

    // Clear request, then a store during the sweep is dropped.
    step(0, 0, 0, 1, 0, 0);
    chk("clr_ready", a_rdy, 0);
    chk("clr_err", a_err, 0);
    step(0, 0, 1, 0, 4'h7, 8'hFF);
    chk("drop_err", a_err, 1);
    chk("drop_rv", a_rv, 0);
    step(0, 0, 0, 0, 0, 0);
    chk("drop_err_pulse", a_err, 0);
    for (int j = 3; j <= 16; j++) begin
      step(0, 0, 0, 0, 0, 0);
      chk($sformatf("sweep_ready_%0d", j), a_rdy, (j == 16));
    end
    sb.push_back(8'h00);
    step(0, 1, 0, 0, 4'h7, 0);
    chk("post_clr_rv", a_rv, 1);
    sb.push_back(8'h00);
    step(0, 1, 0, 0, 4'h3, 0);
    step(0, 0, 0, 0, 0, 0);
    chk("post_clr_rv_drop", a_rv, 0);

    // Instance b: reset mid-sweep at counter 9, then full re-sweep.
    rst[1] = 1'b1;
    for (int k = 1; k <= 9; k++) step(1, 0, 0, 0, 0, 0);
    step(1, 1, 0, 0, 4'h2, 0);
    chk("b_mid_err", b_err, 1);
    chk("b_mid_ready", b_rdy, 0);
    rst[1] = 1'b0;
    #1;
    chk("b_async_err", b_err, 0);
    chk("b_async_ready", b_rdy, 0);
    chk("b_async_rv", b_rv, 0);
    chk("b_async_dq", b_dq, 0);
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    rst[1] = 1'b1;
    for (int k = 1; k <= 17; k++) begin
      step(1, 0, 0, 0, 0, 0);
      chk($sformatf("b_ready_%0d", k), b_rdy, (k == 17));
    end
    for (int k = 0; k < 3; k++) begin
      logic [3:0] ba;
      ba = (k == 0) ? 4'h0 : ((k == 1) ? 4'h9 : 4'hF);
      step(1, 1, 0, 0, ba, 0);
      chk($sformatf("b_rv_%0d", k), b_rv, 1);
      chk($sformatf("b_dq_%0d", k), b_dq, 8'h3C);
    end
    step(1, 0, 0, 0, 0, 0);

    // Instance c: no clear at reset, ready after START only.
    chk("c_rst_ready", c_rdy, 0);
    rst[2] = 1'b1;
    #1;
    chk("c_start_ready", c_rdy, 0);
    step(2, 0, 0, 0, 0, 0);
    chk("c_ready", c_rdy, 1);
    step(2, 0, 1, 0, 4'hF, 8'h96);
    chk("c_wr_err", c_err, 0);
    step(2, 1, 0, 0, 4'hF, 0);
    chk("c_rv", c_rv, 1);
    chk("c_dq", c_dq, 8'h96);
    step(2, 0, 0, 0, 0, 0);
    chk("c_rv_drop", c_rv, 0);
    chk("c_dq_hold", c_dq, 8'h96);

    @(negedge clk);
    chk("sb_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/data_mem_sweep.md
Name: data_mem_sweep

Overview:
Parametrised single-port data memory; next generation of the team's 8x256 data_mem.
- Adds a registered read path with a valid strobe.
- Adds a hardware clear sweep at reset and on request, with a ready/busy handshake.
- Adds an error flag for accesses attempted while the sweep is running.
- Sits between the core's LDR/STR datapath and the controller, which polls ready before the first program access.

Parameters:
- W, 8, data width in bits per entry.
- A, 8, address width; depth is 2**A entries.
- CLEAR_ON_RESET, 1, 1 = start a clear sweep automatically after reset release; 0 = come up ready, array contents undefined.
- CLEAR_VALUE, 0, W-bit value written to every entry by a sweep.

Ports:
- clk, input, 1, rising-edge clock.
- reset, input, 1, asynchronous, active-low reset.
- data_to_write, input, W, store data.
- addr, input, A, single shared read/write address.
- read_enabled, input, 1, load request.
- write_enabled, input, 1, store request.
- clear_request, input, 1, one-cycle pulse that starts a clear sweep.
- data_out, output, W, registered load data.
- read_valid, output, 1, data_out is valid this cycle.
- ready, output, 1, memory accepts accesses.
- access_error, output, 1, one-cycle pulse when an access or clear_request is dropped.

Behaviour:
- Reset is asynchronous and active-low: asserting reset (low) immediately forces the outputs below. Release is sampled on clk.
  - data_out=0, read_valid=0, access_error=0, ready=0.
  - State = START; sweep counter = 0.
  - The array itself is not reset.
- States: START, CLEARING, IDLE.
- START: lasts one cycle after reset release. Goes to CLEARING if CLEAR_ON_RESET=1, else to IDLE.
- CLEARING:
  - Each cycle, core[counter] <= CLEAR_VALUE and the counter increments.
  - ready=0.
  - When counter == 2**A-1, the final entry is written and the next state is IDLE. The counter wraps to 0 and no extra write occurs.
  - A sweep takes exactly 2**A cycles.
- IDLE:
  - ready=1.
  - clear_request=1 sets counter=0 and moves to CLEARING next cycle. Any read or write in the same cycle is still serviced.
- Reads (IDLE only): with read_enabled=1 at edge N, data_out=core[addr] and read_valid=1 from edge N.
  - Latency is 1 cycle.
  - read_valid is high for exactly one cycle per request.
  - data_out holds its last value when read_valid=0. It does not return to 0.
- Writes (IDLE only): with write_enabled=1 at edge N, core[addr]<=data_to_write.
- Simultaneous read and write to the same addr: read-first. data_out returns the old contents and the new value is stored.
- Any read_enabled, write_enabled, or clear_request sampled while ready=0 (START or CLEARING):
  - The request is ignored; no array change and no read_valid.
  - access_error pulses for one cycle.
  - The sweep continues unaffected.
- Reset asserted mid-sweep: the sweep aborts. After release the FSM restarts from START and, with CLEAR_ON_RESET=1, re-sweeps from address 0.
- addr always uses the full A bits, so it is never out of range.

Decomposition:
- Package data_mem_pkg: state enum typedef (START, CLEARING, IDLE) and default width/depth constants shared with the controller.
- Optional sub-module mem_clear_seq: owns the FSM and sweep counter, and outputs the sweep write enable and address.
- The top level muxes the sweep address/data against the core port, and holds the array and read register.

Test Plan (A=4, W=8, CLEAR_VALUE=8'h00 unless stated):
- Hold reset low 3 cycles, then release with CLEAR_ON_RESET=1 -> ready=0 for 1+16 cycles, then ready=1; reads of addrs 0..15 return 8'h00 with read_valid one cycle after each request.
- Write addr 4'h3 = 8'hA5, then read 4'h3 next cycle -> data_out=8'hA5 and read_valid=1 exactly one cycle later; read_valid=0 the cycle after.
- Same cycle: read and write on addr 4'h3, new data 8'h5A, with old value 8'hA5 -> data_out=8'hA5; following read returns 8'h5A.
- Pulse clear_request in IDLE, then write 8'hFF to addr 4'h7 during the sweep -> access_error pulses once, the write is dropped, and after 16 cycles a read of 4'h7 returns 8'h00.
- Assert reset at sweep counter 9 with CLEAR_VALUE=8'h3C, release -> outputs go to reset values immediately; the sweep restarts at 0 and ready rises 17 cycles after release.
- CLEAR_ON_RESET=0 -> ready=1 on the second cycle after reset release; a write then read at addr 4'hF returns the written value.
